// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline register with a 2-entry skid buffer, stall/rdy freeze and flush
// Ports: clk, rst (sync, active-low), rdy, stall, flush; in_* valid/ready upstream side;
//   out_* valid/ready downstream side; occupancy (0..2).
// Optional: PIPE_STAGE_FWD_EN adds fwd_we/fwd_waddr/fwd_data taken from the head entry.
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 10,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter int ADDR_W = 5,
  parameter int STALL_W = 6,
  parameter int STAGE_IDX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic               in_we,
  input  logic [ADDR_W-1:0]  in_waddr,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic               out_we,
  output logic [ADDR_W-1:0]  out_waddr,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         occupancy
`ifdef PIPE_STAGE_FWD_EN
  ,
  output logic               fwd_we,
  output logic [ADDR_W-1:0]  fwd_waddr,
  output logic [DATA_W-1:0]  fwd_data
`endif
);
  localparam int E_W = CTRL_W + 1 + ADDR_W + DATA_W;
  logic [E_W-1:0] h_e_q, h_e_d, s_e_q, s_e_d, in_e;
  logic h_v_q, h_v_d, s_v_q, s_v_d, acc, pop, h_we;
  logic [CTRL_W-1:0] h_ctrl;
  logic [ADDR_W-1:0] h_waddr;
  logic unused_stall;
  assign unused_stall = ^stall;
  assign in_e = {in_ctrl, in_we, in_waddr, in_data};
  assign {h_ctrl, h_we, h_waddr, out_data} = h_e_q;
  assign in_ready = !s_v_q;
  assign acc = in_valid & in_ready & rdy;
  assign pop = h_v_q & out_ready & !stall[STAGE_IDX] & rdy;
  // acc/pop already fold in rdy, so rdy=0 falls through every branch unchanged
  always_comb begin
    h_v_d = h_v_q;
    s_v_d = s_v_q;
    h_e_d = h_e_q;
    s_e_d = s_e_q;
    if (flush) begin
      h_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (!h_v_q || (pop && !s_v_q)) begin
      h_v_d = acc;
      h_e_d = acc ? in_e : h_e_q;
    end else if (pop) begin
      h_e_d = s_e_q;
      s_v_d = acc;
      s_e_d = acc ? in_e : s_e_q;
    end else if (acc) begin
      s_v_d = 1'b1;
      s_e_d = in_e;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_v_q <= 1'b0;
      s_v_q <= 1'b0;
      h_e_q <= '0;
      s_e_q <= '0;
    end else begin
      h_v_q <= h_v_d;
      s_v_q <= s_v_d;
      h_e_q <= h_e_d;
      s_e_q <= s_e_d;
    end
  end
  assign out_valid = h_v_q;
  assign out_ctrl = h_v_q ? h_ctrl : CTRL_NOP;
  assign out_we = h_v_q & h_we;
  assign out_waddr = h_v_q ? h_waddr : '0;
  assign occupancy = {1'b0, h_v_q} + {1'b0, s_v_q};
`ifdef PIPE_STAGE_FWD_EN
  assign fwd_we = out_we;
  assign fwd_waddr = out_waddr;
  assign fwd_data = h_v_q ? out_data : '0;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and random checks of pipe_stage_skid against a queue model
module tb_pipe_stage_skid;
  typedef struct packed {
    logic [9:0]  ctrl;
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] data;
  } ent_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, rdy, flush, in_valid, in_ready, in_we, out_valid, out_ready, out_we;
  logic [5:0] stall;
  logic [9:0] in_ctrl, out_ctrl;
  logic [4:0] in_waddr, out_waddr;
  logic [63:0] in_data, out_data;
  logic [1:0] occupancy;
`ifdef PIPE_STAGE_FWD_EN
  logic fwd_we;
  logic [4:0] fwd_waddr;
  logic [63:0] fwd_data;
`endif
  pipe_stage_skid dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_we(in_we),
    .in_waddr(in_waddr), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_we(out_we), .out_waddr(out_waddr), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_FWD_EN
    , .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_data(fwd_data)
`endif
  );
  ent_t q[$];
  ent_t last;
  int cmp = 0, bad = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic ent_t mk(input logic [63:0] d, input logic we = 1'b1, input logic [4:0] wa = 5'd1);
    ent_t e;
    e.ctrl = d[9:0] | 10'h200;
    e.we = we;
    e.waddr = wa;
    e.data = d;
    return e;
  endfunction
  task automatic check_all();
    ent_t hd;
    logic ev;
    ev = q.size() > 0;
    hd = ev ? q[0] : '0;
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("out_ctrl", 64'(out_ctrl), 64'(hd.ctrl));
    chk("out_we", 64'(out_we), 64'(hd.we));
    chk("out_waddr", 64'(out_waddr), 64'(hd.waddr));
    chk("out_data", out_data, last.data);
`ifdef PIPE_STAGE_FWD_EN
    chk("fwd_we", 64'(fwd_we), 64'(hd.we));
    chk("fwd_waddr", 64'(fwd_waddr), 64'(hd.waddr));
    chk("fwd_data", fwd_data, hd.data);
`endif
  endtask
  task automatic step(input logic r, input logic rd, input logic fl, input logic iv,
                      input logic orr, input logic [5:0] st, input ent_t e);
    logic do_pop, do_acc;
    rst = r; rdy = rd; flush = fl; in_valid = iv; out_ready = orr; stall = st;
    {in_ctrl, in_we, in_waddr, in_data} = e;
    @(posedge clk);
    if (!r) begin
      q.delete();
      last = '0;
    end else if (fl) begin
      q.delete();
    end else if (rd) begin
      do_pop = q.size() > 0 && orr && !st[3];
      do_acc = iv && q.size() < 2;
      if (do_pop) void'(q.pop_front());
      if (do_acc) q.push_back(e);
      if (q.size() > 0) last = q[0];
    end
    @(negedge clk);
    check_all();
  endtask
  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stall = '0;
    in_ctrl = '0; in_we = 1'b0; in_waddr = '0; in_data = '0;
    last = '0;
    @(negedge clk);
    step(0, 1, 0, 1, 0, 0, mk(64'h33));
    step(0, 1, 0, 1, 0, 0, mk(64'h34));
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 1, 0, 1, 1, 0, mk(64'(i)));
      chk("stream_data", out_data, 64'(i));
      chk("stream_valid", 64'(out_valid), 64'd1);
    end
    step(1, 1, 0, 0, 1, 0, '0);
    step(1, 1, 0, 1, 0, 0, mk(64'hA));
    step(1, 1, 0, 1, 0, 0, mk(64'hB));
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_occ", 64'(occupancy), 64'd2);
    step(1, 1, 0, 1, 0, 0, mk(64'hC));
    chk("bp_c_blocked", out_data, 64'hA);
    step(1, 1, 0, 1, 1, 0, mk(64'hC));
    chk("bp_b_next", out_data, 64'hB);
    step(1, 1, 0, 1, 1, 0, mk(64'hC));
    chk("bp_c_last", out_data, 64'hC);
    step(1, 1, 0, 0, 1, 0, '0);
    step(1, 1, 1, 0, 0, 0, '0);
    step(1, 1, 0, 1, 0, 0, mk(64'hAA));
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 1, 6'b001000, '0);
      chk("stall_hold", out_data, 64'hAA);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 1, 0, mk(64'h77));
      chk("rdy_hold", out_data, 64'hAA);
      chk("rdy_occ", 64'(occupancy), 64'd1);
    end
    step(1, 1, 0, 0, 1, 0, '0);
    step(1, 1, 0, 1, 0, 0, mk(64'h11));
    step(1, 1, 0, 1, 0, 0, mk(64'h12));
    step(1, 1, 1, 1, 0, 0, mk(64'h99));
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_we", 64'(out_we), 64'd0);
    step(1, 1, 0, 0, 1, 0, '0);
    chk("flush_dropped", 64'(occupancy), 64'd0);
`ifdef PIPE_STAGE_FWD_EN
    step(1, 1, 0, 1, 0, 0, mk(64'h55, 1'b1, 5'd7));
    chk("fwd_we_full", 64'(fwd_we), 64'd1);
    chk("fwd_waddr_full", 64'(fwd_waddr), 64'd7);
    chk("fwd_data_full", fwd_data, 64'h55);
    step(1, 1, 0, 0, 1, 0, '0);
    chk("fwd_data_empty", fwd_data, 64'd0);
`endif
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 100) != 0, ($urandom % 8) != 0, ($urandom % 30) == 0,
           1'($urandom % 2), ($urandom % 4) != 0, 6'($urandom),
           mk({$urandom, $urandom}, 1'($urandom), 5'($urandom)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
